// File: rtl/program_loader_if.sv
// Byte-stream and main_memory write-port bundle for program_loader.
//   byte_valid / byte_data : stream byte offered by the sender
//   byte_ready             : loader accepts a byte this cycle
//   mem_waddr / mem_wdata  : main_memory word address / write data
//   mem_wen                : main_memory write enable, one pulse per word
// master = loader side, slave = sender/memory side.
interface program_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_wen;

    modport master (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output mem_waddr,
        output mem_wdata,
        output mem_wen
    );

    modport slave (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  mem_waddr,
        input  mem_wdata,
        input  mem_wen
    );
endinterface

// File: rtl/program_loader.sv
// Loads a length-prefixed little-endian byte stream into main_memory and
// holds the cpu in reset until the image is complete.
//   clk, rst       : clock, synchronous active-high reset
//   load_start     : begin a load (honoured in IDLE, DONE, ERROR)
//   bus            : byte stream in, memory write port out
//   cpu_hold       : 1 = cpu held in reset
//   load_done      : image fully written (level)
//   load_error     : image rejected, longer than DEPTH (level)
//   words_written  : words written in the current load
module program_loader #(
    parameter int unsigned DEPTH     = 2048,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_start,
    program_loader_if.master     bus,
    output logic                 cpu_hold,
    output logic                 load_done,
    output logic                 load_error,
    output logic [31:0]          words_written
);
    localparam int unsigned WORD_W = 32;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned ASM_W  = 24;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [ASM_W-1:0]    asm_q, asm_d;
    logic [WORD_W-1:0]   len_q, len_d;
    logic [WORD_W-1:0]   words_q, words_d;
    logic [WORD_W-1:0]   waddr_q, waddr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic                wen_q, wen_d;
    logic                ready_q, ready_d;
    logic                hold_q, hold_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                take;
    logic [WORD_W-1:0]   full_word;

    // Bytes shift in from the top, so after three bytes asm_q = {b2,b1,b0}.
    assign take      = bus.byte_valid & ready_q;
    assign full_word = {bus.byte_data, asm_q};

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        asm_d   = asm_q;
        len_d   = len_q;
        words_d = words_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        wen_d   = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (load_start) begin
                    state_d = S_LEN;
                    idx_d   = '0;
                    words_d = '0;
                end
            end
            S_LEN: begin
                if (take) begin
                    asm_d = {bus.byte_data, asm_q[ASM_W-1:8]};
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(3)) begin
                        len_d = full_word;
                        if (full_word == '0) begin
                            state_d = S_DONE;
                        end else if (full_word > WORD_W'(DEPTH)) begin
                            state_d = S_ERROR;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
            end
            S_DATA: begin
                if (take) begin
                    asm_d = {bus.byte_data, asm_q[ASM_W-1:8]};
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(3)) begin
                        state_d = S_WRITE;
                        wen_d   = 1'b1;
                        waddr_d = WORD_W'(BASE_ADDR) + words_q;
                        wdata_d = full_word;
                    end
                end
            end
            S_WRITE: begin
                words_d = words_q + WORD_W'(1);
                state_d = (words_d == len_q) ? S_DONE : S_DATA;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status flags track the state being entered so they align with state_q.
        ready_d = (state_d == S_LEN) || (state_d == S_DATA);
        hold_d  = (state_d != S_DONE);
        done_d  = (state_d == S_DONE);
        err_d   = (state_d == S_ERROR);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            asm_q   <= '0;
            len_q   <= '0;
            words_q <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            ready_q <= 1'b0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            len_q   <= len_d;
            words_q <= words_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            ready_q <= ready_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.byte_ready = ready_q;
    assign bus.mem_waddr  = waddr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.mem_wen    = wen_q;
    assign cpu_hold       = hold_q;
    assign load_done      = done_q;
    assign load_error     = err_q;
    assign words_written  = words_q;
endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: randomized stalls and images
// compared against a stream-level model of the expected memory writes.
module tb_program_loader;
    localparam int unsigned DEPTH     = 2048;
    localparam int unsigned BASE_ADDR = 0;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;
    logic [31:0] words_written;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    wr_t         wr_q[$];
    int unsigned exp_n;
    bit          exp_err;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];

    program_loader_if bus();

    program_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
        .clk           (clk),
        .rst           (rst),
        .load_start    (load_start),
        .bus           (bus),
        .cpu_hold      (cpu_hold),
        .load_done     (load_done),
        .load_error    (load_error),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    // Record every memory write, sampled mid-cycle.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_wen === 1'b1)
            wr_q.push_back('{addr: bus.mem_waddr, data: bus.mem_wdata, cyc: cyc});
    end

    // Reference: decode the stream into the list of writes it should produce.
    task automatic build_model(input bq_t s);
        exp_addr.delete();
        exp_data.delete();
        exp_n   = {s[3], s[2], s[1], s[0]};
        exp_err = (exp_n > DEPTH);
        if (!exp_err) begin
            for (int i = 0; i < int'(exp_n); i++) begin
                exp_addr.push_back(32'(BASE_ADDR + i));
                exp_data.push_back({s[4+4*i+3], s[4+4*i+2], s[4+4*i+1], s[4+4*i]});
            end
        end
    endtask

    task automatic start_load();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    // Offer the first cnt bytes, with 0..gap_max idle cycles before each.
    task automatic send_bytes(input bq_t s, input int cnt, input int gap_max);
        int gap;
        int w;
        for (int i = 0; i < cnt; i++) begin
            gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            repeat (gap) begin
                bus.byte_valid = 1'b0;
                bus.byte_data  = 8'($urandom);
                @(negedge clk);
            end
            bus.byte_valid = 1'b1;
            bus.byte_data  = s[i];
            w = 0;
            while (bus.byte_ready !== 1'b1 && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (bus.byte_ready !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL byte_ready_timeout byte %0d: byte_ready=%b, required 1", i, bus.byte_ready);
                bus.byte_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        bus.byte_valid = 1'b0;
    endtask

    task automatic wait_end();
        int w = 0;
        while (!(load_done === 1'b1 || load_error === 1'b1) && w < 100) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (!(load_done === 1'b1 || load_error === 1'b1)) begin
            errors++;
            $display("FAIL end_timeout: load_done=%b load_error=%b, required one set", load_done, load_error);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        load_start = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        repeat (3) @(negedge clk);
        checks++; if (bus.byte_ready !== 1'b0) begin errors++; $display("FAIL reset_byte_ready: got %b, required 0", bus.byte_ready); end
        checks++; if (bus.mem_wen !== 1'b0) begin errors++; $display("FAIL reset_mem_wen: got %b, required 0", bus.mem_wen); end
        checks++; if (bus.mem_waddr !== 32'h0) begin errors++; $display("FAIL reset_mem_waddr: got %h, required 0", bus.mem_waddr); end
        checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h, required 0", bus.mem_wdata); end
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL reset_cpu_hold: got %b, required 1", cpu_hold); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset_load_done: got %b, required 0", load_done); end
        checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL reset_load_error: got %b, required 0", load_error); end
        checks++; if (words_written !== 32'h0) begin errors++; $display("FAIL reset_words_written: got %0d, required 0", words_written); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.byte_ready !== 1'b0) begin errors++; $display("FAIL idle_byte_ready: got %b, required 0", bus.byte_ready); end
    endtask

    task automatic test_full_rate();
        bq_t s = {8'h02, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h13, 8'h00, 8'h00, 8'h00};
        build_model(s);
        wr_q.delete();
        start_load();
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL full_hold_during: got %b, required 1", cpu_hold); end
        send_bytes(s, s.size(), 0);
        wait_end();
        checks++; if (wr_q.size() != exp_addr.size()) begin errors++; $display("FAIL full_write_count: got %0d, required %0d", wr_q.size(), exp_addr.size()); end
        for (int i = 0; i < wr_q.size() && i < exp_addr.size(); i++) begin
            checks++;
            if (wr_q[i].addr !== exp_addr[i] || wr_q[i].data !== exp_data[i]) begin
                errors++;
                $display("FAIL full_write%0d: got %h@%h, required %h@%h", i, wr_q[i].data, wr_q[i].addr, exp_data[i], exp_addr[i]);
            end
        end
        if (wr_q.size() >= 2) begin
            checks++;
            if (wr_q[1].cyc - wr_q[0].cyc !== 5) begin errors++; $display("FAIL full_wen_spacing: got %0d, required 5", wr_q[1].cyc - wr_q[0].cyc); end
        end
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL full_load_done: got %b, required 1", load_done); end
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL full_cpu_hold: got %b, required 0", cpu_hold); end
        checks++; if (words_written !== exp_n) begin errors++; $display("FAIL full_words_written: got %0d, required %0d", words_written, exp_n); end
    endtask

    task automatic test_zero_len();
        bq_t s = {8'h00, 8'h00, 8'h00, 8'h00};
        build_model(s);
        wr_q.delete();
        start_load();
        send_bytes(s, s.size(), 0);
        wait_end();
        repeat (3) @(negedge clk);
        checks++; if (wr_q.size() != exp_addr.size()) begin errors++; $display("FAIL zero_writes: got %0d, required %0d", wr_q.size(), exp_addr.size()); end
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL zero_load_done: got %b, required 1", load_done); end
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL zero_cpu_hold: got %b, required 0", cpu_hold); end
        checks++; if (words_written !== exp_n) begin errors++; $display("FAIL zero_words_written: got %0d, required %0d", words_written, exp_n); end
    endtask

    task automatic test_too_long();
        bq_t s = {8'h01, 8'h08, 8'h00, 8'h00};
        build_model(s);
        wr_q.delete();
        start_load();
        send_bytes(s, s.size(), 0);
        wait_end();
        checks++; if (load_error !== exp_err) begin errors++; $display("FAIL long_load_error: got %b, required %b", load_error, exp_err); end
        // A sender keeps offering data; nothing may be accepted or written.
        for (int i = 0; i < 8; i++) begin
            bus.byte_valid = 1'b1;
            bus.byte_data  = 8'($urandom);
            @(negedge clk);
            checks++; if (bus.byte_ready !== 1'b0) begin errors++; $display("FAIL long_byte_ready cyc%0d: got %b, required 0", i, bus.byte_ready); end
        end
        bus.byte_valid = 1'b0;
        checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL long_writes: got %0d, required 0", wr_q.size()); end
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL long_cpu_hold: got %b, required 1", cpu_hold); end
        checks++; if (load_error !== 1'b1) begin errors++; $display("FAIL long_error_sticky: got %b, required 1", load_error); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL long_load_done: got %b, required 0", load_done); end
    endtask

    task automatic test_stalls();
        bq_t s;
        int  n;
        for (int it = 0; it < 5; it++) begin
            if (it == 0) begin
                s = {8'h02, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h13, 8'h00, 8'h00, 8'h00};
            end else begin
                n = int'($urandom_range(8, 1));
                s = {8'(n), 8'h00, 8'h00, 8'h00};
                for (int b = 0; b < 4 * n; b++) s.push_back(8'($urandom));
            end
            build_model(s);
            wr_q.delete();
            start_load();
            send_bytes(s, s.size(), 3);
            wait_end();
            checks++; if (wr_q.size() != exp_addr.size()) begin errors++; $display("FAIL stall%0d_write_count: got %0d, required %0d", it, wr_q.size(), exp_addr.size()); end
            for (int i = 0; i < wr_q.size() && i < exp_addr.size(); i++) begin
                checks++;
                if (wr_q[i].addr !== exp_addr[i] || wr_q[i].data !== exp_data[i]) begin
                    errors++;
                    $display("FAIL stall%0d_write%0d: got %h@%h, required %h@%h", it, i, wr_q[i].data, wr_q[i].addr, exp_data[i], exp_addr[i]);
                end
            end
            checks++; if (words_written !== exp_n) begin errors++; $display("FAIL stall%0d_words_written: got %0d, required %0d", it, words_written, exp_n); end
            checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL stall%0d_load_done: got %b, required 1", it, load_done); end
        end
    endtask

    task automatic test_mid_reset();
        bq_t s = {8'h02, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h13, 8'h00, 8'h00, 8'h00};
        wr_q.delete();
        start_load();
        send_bytes(s, 6, 0);
        rst = 1'b1;
        bus.byte_valid = 1'b1;
        bus.byte_data  = s[6];
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.byte_ready !== 1'b0) begin errors++; $display("FAIL mrst_byte_ready: got %b, required 0", bus.byte_ready); end
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL mrst_cpu_hold: got %b, required 1", cpu_hold); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL mrst_load_done: got %b, required 0", load_done); end
        checks++; if (words_written !== 32'h0) begin errors++; $display("FAIL mrst_words_written: got %0d, required 0", words_written); end
        checks++; if (bus.mem_waddr !== 32'h0 || bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL mrst_mem_bus: got %h@%h, required 0@0", bus.mem_wdata, bus.mem_waddr); end
        rst = 1'b0;
        bus.byte_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL mrst_writes: got %0d, required 0", wr_q.size()); end
        checks++; if (bus.byte_ready !== 1'b0) begin errors++; $display("FAIL mrst_idle_ready: got %b, required 0", bus.byte_ready); end
        test_full_rate();
    endtask

    task automatic test_reload();
        bq_t s = {8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL reload_pre_done: got %b, required 1", load_done); end
        build_model(s);
        wr_q.delete();
        start_load();
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL reload_hold: got %b, required 1", cpu_hold); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reload_done_clear: got %b, required 0", load_done); end
        send_bytes(s, 4, 0);
        checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL reload_hold_mid: got %b, required 1", cpu_hold); end
        send_bytes(s[4:7], 4, 0);
        wait_end();
        checks++; if (wr_q.size() != exp_addr.size()) begin errors++; $display("FAIL reload_write_count: got %0d, required %0d", wr_q.size(), exp_addr.size()); end
        if (wr_q.size() >= 1) begin
            checks++;
            if (wr_q[0].addr !== exp_addr[0] || wr_q[0].data !== exp_data[0]) begin
                errors++;
                $display("FAIL reload_write0: got %h@%h, required %h@%h", wr_q[0].data, wr_q[0].addr, exp_data[0], exp_addr[0]);
            end
        end
        checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL reload_done: got %b, required 1", load_done); end
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL reload_release: got %b, required 0", cpu_hold); end
        checks++; if (words_written !== exp_n) begin errors++; $display("FAIL reload_words_written: got %0d, required %0d", words_written, exp_n); end
    endtask

    initial begin
        rst = 1'b1;
        load_start = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        @(negedge clk);
        test_reset();
        test_full_rate();
        test_zero_len();
        test_too_long();
        test_stalls();
        test_mid_reset();
        test_reload();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
